proc_control: RTL and testbench

PROC_CONTROL -- requirements
Module: proc_control

---
 rtl/proc_control_pkg.sv | 22 ++
 rtl/proc_control_step_counter.sv | 24 ++
 rtl/proc_control.sv | 111 +++++++++++
 tb/tb_proc_control.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/proc_control_pkg.sv
// Shared definitions for the processor control unit: opcodes, step
// encodings and the register-index decode helper.
package proc_control_pkg;

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } step_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // Register index to one-hot enable vector (R0..R7).
  function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/proc_control_step_counter.sv
// Two-bit step counter. Clear has priority over enable; both are driven
// by the control FSM's next-step decision.
module step_counter (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [1:0] o_count
);

  logic [1:0] r_count;

  // Step register: reset or clear returns to step 0, enable advances one step.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_count <= 2'b00;
    end else if (i_en) begin
      r_count <= r_count + 2'b01;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/proc_control.sv
// Control unit for a simple bus-based processor. A four-step sequencer
// (T0..T3) decodes the instruction register and produces the register
// load/drive enables and ALU strobes for mv, mvi, add and sub.
module proc_control
  import proc_control_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_run,
  input  logic [8:0] i_ir,
  output logic [7:0] o_rin,
  output logic [7:0] o_rout,
  output logic       o_ain,
  output logic       o_gin,
  output logic       o_gout,
  output logic       o_dinout,
  output logic       o_irin,
  output logic       o_addsub,
  output logic       o_done,
  output logic [1:0] o_tstep
);

  logic [1:0] w_count;
  step_t      w_step;
  logic       w_clr;
  logic       w_en;
  logic [2:0] w_op;
  logic [7:0] w_x_oh;
  logic [7:0] w_y_oh;
  logic       w_is_alu;

  assign w_op     = i_ir[8:6];
  assign w_x_oh   = reg_onehot(i_ir[5:3]);
  assign w_y_oh   = reg_onehot(i_ir[2:0]);
  assign w_is_alu = (w_op == OP_ADD) || (w_op == OP_SUB);
  assign w_step   = step_t'(w_count);

  step_counter u_step_counter (
    .i_clk   (i_clk),
    .i_rst   (i_reset),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .o_count (w_count)
  );

  // Next-step decision and output decode; every output defaults to idle.
  always_comb begin
    w_clr    = 1'b0;
    w_en     = 1'b0;
    o_rin    = 8'h00;
    o_rout   = 8'h00;
    o_ain    = 1'b0;
    o_gin    = 1'b0;
    o_gout   = 1'b0;
    o_dinout = 1'b0;
    o_irin   = 1'b0;
    o_addsub = 1'b0;
    o_done   = 1'b0;
    unique case (w_step)
      T0: begin
        // IR is not consulted here; it is being loaded.
        o_irin = i_run;
        w_en   = i_run;
      end
      T1: begin
        if (w_op == OP_MV) begin
          o_rout = w_y_oh;
          o_rin  = w_x_oh;
          o_done = 1'b1;
          w_clr  = 1'b1;
        end else if (w_op == OP_MVI) begin
          o_dinout = 1'b1;
          o_rin    = w_x_oh;
          o_done   = 1'b1;
          w_clr    = 1'b1;
        end else if (w_is_alu) begin
          o_rout = w_x_oh;
          o_ain  = 1'b1;
          w_en   = 1'b1;
        end else begin
          // Undefined opcode behaves as a NOP that still signals completion.
          o_done = 1'b1;
          w_clr  = 1'b1;
        end
      end
      T2: begin
        if (w_is_alu) begin
          o_rout   = w_y_oh;
          o_gin    = 1'b1;
          o_addsub = (w_op == OP_SUB);
          w_en     = 1'b1;
        end else begin
          // Only reachable if IR changed mid-instruction; recover quietly.
          w_clr = 1'b1;
        end
      end
      T3: begin
        if (w_is_alu) begin
          o_gout = 1'b1;
          o_rin  = w_x_oh;
          o_done = 1'b1;
        end
        w_clr = 1'b1;
      end
      default: w_clr = 1'b1;
    endcase
  end

  assign o_tstep = w_count;

endmodule

// File: tb/tb_proc_control.sv
// Self-checking bench for proc_control: directed instruction scenarios
// followed by random traffic, all compared against a per-instruction
// micro-step model.
module tb_proc_control;

  typedef struct packed {
    logic [7:0] rin;
    logic [7:0] rout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       dinout;
    logic       irin;
    logic       addsub;
    logic       done;
    logic [1:0] tstep;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [8:0] ir  = 9'h000;
  logic [7:0] rin, rout;
  logic       ain, gin, gout, dinout, irin, addsub, done;
  logic [1:0] tstep;

  int    checks   = 0;
  int    failures = 0;
  int    mpos     = 0;
  outs_t last_obs;

  proc_control dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_run    (run),
    .i_ir     (ir),
    .o_rin    (rin),
    .o_rout   (rout),
    .o_ain    (ain),
    .o_gin    (gin),
    .o_gout   (gout),
    .o_dinout (dinout),
    .o_irin   (irin),
    .o_addsub (addsub),
    .o_done   (done),
    .o_tstep  (tstep)
  );

  always #5 clk = ~clk;

  // Instruction length in cycles, counting the fetch step.
  function automatic int instr_len(input logic [8:0] i);
    int op;
    op = int'(i[8:6]);
    return (op == 2 || op == 3) ? 4 : 2;
  endfunction

  // Expected outputs for cycle number pos of the current instruction.
  function automatic outs_t model_out(input int pos, input logic r, input logic [8:0] i);
    outs_t e;
    int op, x, y;
    op = int'(i[8:6]);
    x  = int'(i[5:3]);
    y  = int'(i[2:0]);
    e  = '0;
    e.tstep = 2'(pos);
    if (pos == 0) begin
      e.irin = r;
    end else if (pos == 1) begin
      case (op)
        0: begin e.rout = 8'(1 << y); e.rin = 8'(1 << x); e.done = 1'b1; end
        1: begin e.dinout = 1'b1; e.rin = 8'(1 << x); e.done = 1'b1; end
        2, 3: begin e.rout = 8'(1 << x); e.ain = 1'b1; end
        default: e.done = 1'b1;
      endcase
    end else if (pos == 2) begin
      e.rout   = 8'(1 << y);
      e.gin    = 1'b1;
      e.addsub = (op == 3);
    end else begin
      e.gout = 1'b1;
      e.rin  = 8'(1 << x);
      e.done = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One clock cycle: drive, check mid-cycle, then advance the model.
  task automatic cyc(input string tag, input logic r, input logic rn, input logic [8:0] i);
    outs_t exp_o, obs;
    int ob_cnt;
    rst = r;
    run = rn;
    ir  = i;
    @(negedge clk);
    obs = '{rin, rout, ain, gin, gout, dinout, irin, addsub, done, tstep};
    exp_o = model_out(mpos, rn, i);
    chk(tag, 32'(obs), 32'(exp_o));
    chk({tag, "_rin_1hot"}, 32'($countones(rin) <= 1), 32'd1);
    chk({tag, "_rout_1hot"}, 32'($countones(rout) <= 1), 32'd1);
    ob_cnt = int'(|rout) + int'(gout) + int'(dinout);
    chk({tag, "_bus_src"}, 32'(ob_cnt <= 1), 32'd1);
    last_obs = obs;
    @(posedge clk);
    if (r) mpos = 0;
    else if (mpos == 0) mpos = rn ? 1 : 0;
    else if (mpos + 1 >= instr_len(i)) mpos = 0;
    else mpos = mpos + 1;
    #1;
  endtask

  initial begin
    int dones;
    logic [7:0] rin_acc;
    logic [8:0] cur_ir;
    logic r, rn;
    @(posedge clk);
    #1;

    // Reset for two cycles, then idle.
    cyc("reset0", 1'b1, 1'b0, 9'h000);
    cyc("reset1", 1'b1, 1'b0, 9'h000);
    cyc("idle", 1'b0, 1'b0, 9'b001_011_000);
    chk("idle_all_zero", 32'(last_obs), 32'd0);

    // mvi R3 with a one-cycle Run pulse.
    cyc("mvi_t0", 1'b0, 1'b1, 9'b001_011_000);
    chk("mvi_t0_irin", 32'(last_obs.irin), 32'd1);
    cyc("mvi_t1", 1'b0, 1'b0, 9'b001_011_000);
    chk("mvi_t1_rin", 32'(last_obs.rin), 32'h08);
    chk("mvi_t1_din", 32'({last_obs.dinout, last_obs.done}), 32'b11);
    cyc("mvi_idle", 1'b0, 1'b0, 9'b001_011_000);
    chk("mvi_idle_zero", 32'(last_obs), 32'd0);

    // add R1,R2.
    cyc("add_t0", 1'b0, 1'b1, 9'b010_001_010);
    cyc("add_t1", 1'b0, 1'b0, 9'b010_001_010);
    chk("add_t1_rout", 32'(last_obs.rout), 32'h02);
    cyc("add_t2", 1'b0, 1'b0, 9'b010_001_010);
    chk("add_t2_rout", 32'(last_obs.rout), 32'h04);
    chk("add_t2_addsub", 32'(last_obs.addsub), 32'd0);
    cyc("add_t3", 1'b0, 1'b0, 9'b010_001_010);
    chk("add_t3_rin", 32'(last_obs.rin), 32'h02);
    chk("add_t3_gout_done", 32'({last_obs.gout, last_obs.done}), 32'b11);

    // sub R7,R7 with Run held for 8 cycles: two back-to-back instructions.
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      cyc("sub_bb", 1'b0, 1'b1, 9'b011_111_111);
      if (last_obs.done) dones++;
      if (k % 4 == 2) chk("sub_t2_addsub", 32'(last_obs.addsub), 32'd1);
      if (k % 4 == 3) chk("sub_t3_done", 32'(last_obs.done), 32'd1);
    end
    chk("sub_done_count", 32'(dones), 32'd2);
    cyc("sub_after", 1'b0, 1'b0, 9'b011_111_111);
    chk("sub_after_zero", 32'(last_obs), 32'd0);

    // add abandoned by reset during T2.
    rin_acc = 8'h00;
    dones = 0;
    cyc("abort_t0", 1'b0, 1'b1, 9'b010_001_010);
    rin_acc |= last_obs.rin;
    cyc("abort_t1", 1'b0, 1'b0, 9'b010_001_010);
    rin_acc |= last_obs.rin;
    cyc("abort_t2", 1'b1, 1'b0, 9'b010_001_010);
    rin_acc |= last_obs.rin;
    if (last_obs.done) dones++;
    for (int k = 0; k < 3; k++) begin
      cyc("abort_after", 1'b0, 1'b0, 9'b010_001_010);
      rin_acc |= last_obs.rin;
      if (last_obs.done) dones++;
    end
    chk("abort_tstep", 32'(last_obs.tstep), 32'd0);
    chk("abort_no_rin", 32'(rin_acc), 32'd0);
    chk("abort_no_done", 32'(dones), 32'd0);

    // Undefined opcode behaves as NOP with Done.
    cyc("nop_t0", 1'b0, 1'b1, 9'b110_000_000);
    cyc("nop_t1", 1'b0, 1'b0, 9'b110_000_000);
    chk("nop_t1_done_only", 32'(last_obs), 32'({8'h00, 8'h00, 7'b0000001, 2'b01}));

    // Random traffic; IR only changes while the model is in the fetch step.
    cur_ir = 9'h000;
    for (int k = 0; k < 400; k++) begin
      if (mpos == 0) cur_ir = 9'($urandom);
      r  = ($urandom_range(0, 19) == 0);
      rn = 1'($urandom);
      cyc("rand", r, rn, cur_ir);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
